// File: rtl/pipe_check_pkg.sv
// Shared Pipe In/Pipe Out pattern definitions: seeds, checker FSM states and
// the per-lane next-word function used by both generator and checker.
package pipe_check_pkg;

    localparam logic [63:0] SEED_COUNT = 64'h0000_0001_0000_0001;
    localparam logic [63:0] SEED_LFSR  = 64'h0D0C_0B0A_0403_0201;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // lfsr=0: counter lane; lfsr=1: x^32+x^22+x^2+1 shifting left
    function automatic logic [31:0] lane_next(input logic [31:0] lane, input logic lfsr);
        logic [31:0] nxt;
        if (lfsr)
            nxt = {lane[30:0], lane[31] ^ lane[21] ^ lane[1]};
        else
            nxt = lane + 32'd1;
        return nxt;
    endfunction

    function automatic logic [63:0] seed_word(input logic lfsr);
        return lfsr ? SEED_LFSR : SEED_COUNT;
    endfunction

endpackage

// File: rtl/pipe_pattern_gen.sv
// Holds the expected 64-bit word; two independent 32-bit lanes advance per
// compared word using the mode latched at load.
module pipe_pattern_gen
    import pipe_check_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        seed_lfsr,
    input  logic        advance,
    output logic [63:0] expected
);

    logic lfsr_mode;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            expected  <= '0;
            lfsr_mode <= 1'b0;
        end else if (load) begin
            expected  <= seed_word(seed_lfsr);
            lfsr_mode <= seed_lfsr;
        end else if (advance) begin
            expected  <= {lane_next(expected[63:32], lfsr_mode),
                          lane_next(expected[31:0],  lfsr_mode)};
        end
    end

endmodule

// File: rtl/pipe_in_check.sv
// Pipe In consumer/checker: throttled FIFO reads, per-word compare against the
// Count/LFSR pattern, word and error statistics with first-mismatch capture.
module pipe_in_check
    import pipe_check_pkg::*;
#(
    parameter int COUNT_W = 9,
    parameter int ERR_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pipe_in_start,
    input  logic               pipe_in_stop,
    input  logic [COUNT_W-1:0] pipe_in_count,
    output logic               pipe_in_read,
    input  logic [63:0]        pipe_in_data,
    input  logic               throttle_set,
    input  logic [31:0]        throttle_val,
    input  logic               mode,
    input  logic [31:0]        word_target,
    output logic               busy,
    output logic               done,
    output logic [31:0]        words_checked,
    output logic [ERR_W-1:0]   error_count,
    output logic [31:0]        first_err_index,
    output logic [63:0]        first_err_expect,
    output logic [63:0]        first_err_actual
);

    state_t      state, state_next;
    logic [31:0] throttle;
    logic [31:0] target;
    logic [31:0] reads_issued;
    logic        rd_d;
    logic [63:0] expected;
    logic        available;
    logic        under_target;
    logic        target_hit;
    logic        issue;
    logic        mismatch;

    // A read already in flight will consume the last word when count==1
    assign available    = (pipe_in_count >= COUNT_W'(2)) ||
                          ((pipe_in_count == COUNT_W'(1)) && !pipe_in_read);
    assign under_target = (target == 32'd0) || (reads_issued < target);
    assign target_hit   = (target != 32'd0) && (reads_issued == target);
    assign issue        = (state == RUN) && !pipe_in_start && !pipe_in_stop &&
                          throttle[0] && available && under_target;
    assign mismatch     = (pipe_in_data != expected);

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (pipe_in_stop || target_hit) state_next = DRAIN;
            DRAIN:   if (!rd_d && !pipe_in_read) state_next = DONE;
            default: state_next = state;
        endcase
        if (pipe_in_start) state_next = RUN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            throttle     <= 32'hFFFF_FFFF;
            target       <= '0;
            reads_issued <= '0;
            pipe_in_read <= 1'b0;
            rd_d         <= 1'b0;
        end else begin
            state    <= state_next;
            throttle <= throttle_set ? throttle_val : {throttle[0], throttle[31:1]};
            // A restart drops the in-flight word by clearing rd_d
            rd_d         <= pipe_in_start ? 1'b0 : pipe_in_read;
            pipe_in_read <= issue;
            if (pipe_in_start) begin
                target       <= word_target;
                reads_issued <= '0;
            end else if (issue) begin
                reads_issued <= reads_issued + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            words_checked    <= '0;
            error_count      <= '0;
            first_err_index  <= '0;
            first_err_expect <= '0;
            first_err_actual <= '0;
        end else if (pipe_in_start) begin
            words_checked    <= '0;
            error_count      <= '0;
            first_err_index  <= '0;
            first_err_expect <= '0;
            first_err_actual <= '0;
        end else if (rd_d) begin
            words_checked <= words_checked + 32'd1;
            if (mismatch) begin
                if (error_count != {ERR_W{1'b1}})
                    error_count <= error_count + ERR_W'(1);
                if (error_count == '0) begin
                    first_err_index  <= words_checked;
                    first_err_expect <= expected;
                    first_err_actual <= pipe_in_data;
                end
            end
        end
    end

    // Expected advances on every compared word so one bad word costs one error
    pipe_pattern_gen u_pattern (
        .clk       (clk),
        .reset     (reset),
        .load      (pipe_in_start),
        .seed_lfsr (mode),
        .advance   (rd_d && !pipe_in_start),
        .expected  (expected)
    );

endmodule
